// File: rtl/sd_fifo_bufhead_s.sv
// Write-side head of a buffered S-FIFO: skid buffer in, memory writes out.
// Optional occupancy output enabled by SD_FIFO_BUFHEAD_USAGE_EN.
module sd_fifo_bufhead_s #(
   parameter int depth  = 16,
   parameter int width  = 8,
   parameter int skid   = 2,
   parameter int wr_lat = 1,
   parameter int async  = 0,
   parameter int asz    = $clog2(depth)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             c_srdy,
   output logic             c_drdy,
   input  logic [width-1:0] c_data,
   output logic             wr_en,
   output logic [asz-1:0]   wr_addr,
   output logic [width-1:0] wr_data,
   output logic [asz:0]     wrptr_head,
   input  logic [asz:0]     rdptr_tail
`ifdef SD_FIFO_BUFHEAD_USAGE_EN
   ,
   output logic [asz:0]     c_usage
`endif
);

   localparam int PW = (skid > 1) ? $clog2(skid) : 1;
   localparam int CW = $clog2(skid + 1);
   localparam logic [PW-1:0] LP_PLAST = PW'(skid - 1);
   localparam logic [CW-1:0] LP_SKID  = CW'(skid);

   logic [width-1:0] r_skid [skid];
   logic [PW-1:0]    r_hptr;
   logic [PW-1:0]    r_tptr;
   logic [CW-1:0]    r_cnt;
   logic [asz:0]     r_wrptr;
   logic [asz:0]     r_dly [wr_lat];
   logic [asz:0]     w_rdptr;
   logic [asz:0]     w_wrenc;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   // Full compares against the undelayed write pointer.
   assign w_full = (r_wrptr[asz-1:0] == w_rdptr[asz-1:0]) &
                   (r_wrptr[asz] != w_rdptr[asz]);

   // Ready comes only from the registered count; no pass-through.
   assign c_drdy = reset_n & (r_cnt < LP_SKID);

   assign w_push     = c_srdy & c_drdy;
   assign w_pop      = (r_cnt != '0) & ~w_full;
   assign wr_en      = w_pop;
   assign wr_addr    = r_wrptr[asz-1:0];
   assign wr_data    = r_skid[r_hptr];
   assign wrptr_head = r_dly[wr_lat-1];

   // Skid storage; contents need no reset since the count gates them.
   always_ff @(posedge clk) begin
      if (w_push) r_skid[r_tptr] <= c_data;
   end

   // Skid pointers, skid count and internal write pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tptr  <= '0;
         r_hptr  <= '0;
         r_cnt   <= '0;
         r_wrptr <= '0;
      end else begin
         if (w_push)
            r_tptr <= (r_tptr == LP_PLAST) ? '0 : r_tptr + 1'b1;
         if (w_pop) begin
            r_hptr  <= (r_hptr == LP_PLAST) ? '0 : r_hptr + 1'b1;
            r_wrptr <= r_wrptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Publish the write pointer only after the memory write has landed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < wr_lat; i++) r_dly[i] <= '0;
      end else begin
         r_dly[0] <= w_wrenc;
         for (int i = 1; i < wr_lat; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   if (async != 0) begin : g_async
      logic [asz:0] r_sync1;
      logic [asz:0] r_sync2;
      logic [asz:0] w_bin;

      // Two-flop synchronizer for the gray read pointer.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
         end else begin
            r_sync1 <= rdptr_tail;
            r_sync2 <= r_sync1;
         end
      end

      // Gray to binary: bit i is the XOR of gray bits i..msb.
      always_comb begin
         w_bin = '0;
         for (int i = 0; i <= asz; i++) w_bin[i] = ^(r_sync2 >> i);
      end

      assign w_rdptr = w_bin;
      assign w_wrenc = r_wrptr ^ (r_wrptr >> 1);
   end else begin : g_sync
      assign w_rdptr = rdptr_tail;
      assign w_wrenc = r_wrptr;
   end

`ifdef SD_FIFO_BUFHEAD_USAGE_EN
   logic [asz:0] r_usage;

   // Registered memory occupancy, skid entries excluded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_usage <= '0;
      else          r_usage <= r_wrptr - w_rdptr;
   end

   assign c_usage = r_usage;
`endif

endmodule

// File: tb/tb_sd_fifo_bufhead_s.sv
// Bench for sd_fifo_bufhead_s: vector table plus scoreboarded sequences.
// Covers single word, fill/drain, wrap, async sync delay and mid-op reset.
module tb_sd_fifo_bufhead_s;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       srdy, drdy, wen;
   logic [7:0] data, wdata;
   logic [1:0] waddr;
   logic [2:0] head, rdp;

   logic       srdy_a, drdy_a, wen_a;
   logic [7:0] data_a, wdata_a;
   logic [1:0] waddr_a;
   logic [2:0] head_a, rdp_a;

`ifdef SD_FIFO_BUFHEAD_USAGE_EN
   logic [2:0] usage, usage_a;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] q[$];
   int         m_wp;
   int         nwr;

   typedef struct {
      bit         rst;
      bit         srdy;
      logic [7:0] d;
      logic [2:0] rdp;
      bit         e_drdy;
      bit         e_wen;
      logic [1:0] e_addr;
      logic [2:0] e_head;
   } vec_t;

   vec_t tv[16];

   always #5 clk = ~clk;

   sd_fifo_bufhead_s #(
      .depth(4), .width(8), .skid(2), .wr_lat(1), .async(0)
   ) u_dut (
      .clk(clk), .reset_n(rst_n),
      .c_srdy(srdy), .c_drdy(drdy), .c_data(data),
      .wr_en(wen), .wr_addr(waddr), .wr_data(wdata),
      .wrptr_head(head), .rdptr_tail(rdp)
`ifdef SD_FIFO_BUFHEAD_USAGE_EN
      , .c_usage(usage)
`endif
   );

   sd_fifo_bufhead_s #(
      .depth(4), .width(8), .skid(2), .wr_lat(1), .async(1)
   ) u_dut_a (
      .clk(clk), .reset_n(rst_n),
      .c_srdy(srdy_a), .c_drdy(drdy_a), .c_data(data_a),
      .wr_en(wen_a), .wr_addr(waddr_a), .wr_data(wdata_a),
      .wrptr_head(head_a), .rdptr_tail(rdp_a)
`ifdef SD_FIFO_BUFHEAD_USAGE_EN
      , .c_usage(usage_a)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Scoreboard step, called at the negedge of each sync-DUT cycle.
   task automatic sb();
      logic [7:0] e;
      if (wen === 1'b1) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_write", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("sb_wr_data", {24'd0, wdata}, {24'd0, e});
            chk("sb_wr_addr", {30'd0, waddr}, 32'(m_wp % 4));
         end
         m_wp++;
         nwr++;
      end
      if (srdy && drdy) q.push_back(data);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      srdy   = 1'b0;
      srdy_a = 1'b0;
      data   = '0;
      data_a = '0;
      rdp    = '0;
      rdp_a  = '0;
      q.delete();
      m_wp = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int sent, acc, nw0;
      bit wrapped;
      logic [2:0] prevh;

      tv[0]  = '{1'b1, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b0, 2'd0, 3'd0};
      tv[1]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 2'd0, 3'd0};
      tv[2]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 2'd1, 3'd0};
      tv[3]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 2'd1, 3'd1};
      tv[4]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 2'd1, 3'd1};
      tv[5]  = '{1'b1, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 2'd0, 3'd0};
      tv[6]  = '{1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 2'd0, 3'd0};
      tv[7]  = '{1'b0, 1'b1, 8'h02, 3'd0, 1'b1, 1'b1, 2'd1, 3'd0};
      tv[8]  = '{1'b0, 1'b1, 8'h03, 3'd0, 1'b1, 1'b1, 2'd2, 3'd1};
      tv[9]  = '{1'b0, 1'b1, 8'h04, 3'd0, 1'b1, 1'b1, 2'd3, 3'd2};
      tv[10] = '{1'b0, 1'b1, 8'h05, 3'd0, 1'b1, 1'b0, 2'd0, 3'd3};
      tv[11] = '{1'b0, 1'b1, 8'h06, 3'd0, 1'b0, 1'b0, 2'd0, 3'd4};
      tv[12] = '{1'b0, 1'b1, 8'h06, 3'd0, 1'b0, 1'b0, 2'd0, 3'd4};
      tv[13] = '{1'b0, 1'b1, 8'h06, 3'd1, 1'b0, 1'b1, 2'd0, 3'd4};
      tv[14] = '{1'b0, 1'b1, 8'h06, 3'd1, 1'b1, 1'b0, 2'd1, 3'd4};
      tv[15] = '{1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 2'd1, 3'd5};

      nwr    = 0;
      m_wp   = 0;
      rst_n  = 1'b0;
      srdy   = 1'b0;
      srdy_a = 1'b0;
      data   = '0;
      data_a = '0;
      rdp    = '0;
      rdp_a  = '0;

      // Outputs while reset is held.
      #2;
      chk("rst_hold_drdy", {31'd0, drdy}, 32'd0);
      chk("rst_hold_wen", {31'd0, wen}, 32'd0);
      chk("rst_hold_head", {29'd0, head}, 32'd0);

      // Idle state just after release.
      do_reset();
      @(negedge clk);
      chk("rst_drdy", {31'd0, drdy}, 32'd1);
      chk("rst_wen", {31'd0, wen}, 32'd0);
      chk("rst_addr", {30'd0, waddr}, 32'd0);
      chk("rst_head", {29'd0, head}, 32'd0);
      @(posedge clk);
      #1;

      // Single word, fill and drain vectors.
      for (int i = 0; i < 16; i++) begin
         if (tv[i].rst) do_reset();
         srdy = tv[i].srdy;
         data = tv[i].d;
         rdp  = tv[i].rdp;
         @(negedge clk);
         chk($sformatf("row%0d drdy", i), {31'd0, drdy},
             {31'd0, tv[i].e_drdy});
         chk($sformatf("row%0d wen", i), {31'd0, wen},
             {31'd0, tv[i].e_wen});
         chk($sformatf("row%0d addr", i), {30'd0, waddr},
             {30'd0, tv[i].e_addr});
         chk($sformatf("row%0d head", i), {29'd0, head},
             {29'd0, tv[i].e_head});
         sb();
         @(posedge clk);
         #1;
      end

      // Wrap: tail follows the published pointer.
      do_reset();
      sent    = 0;
      nw0     = nwr;
      wrapped = 1'b0;
      prevh   = head;
      for (int c = 0; c < 200; c++) begin
         rdp  = head;
         srdy = (sent < 12);
         data = 8'(8'h30 + sent);
         @(negedge clk);
         if (srdy && drdy) sent++;
         sb();
         if (prevh == 3'd7 && head == 3'd0) wrapped = 1'b1;
         prevh = head;
         @(posedge clk);
         #1;
         if (sent == 12 && q.size() == 0 && head == 3'd4) break;
      end
      srdy = 1'b0;
      chk("wrap_sent", sent, 12);
      chk("wrap_writes", nwr - nw0, 12);
      chk("wrap_7to0", {31'd0, wrapped}, 32'd1);
      chk("wrap_head", {29'd0, head}, 32'd4);

      // Async: gray pointers and two-flop read pointer sync.
      do_reset();
      acc = 0;
      for (int c = 0; c < 40 && acc < 5; c++) begin
         srdy_a = 1'b1;
         data_a = 8'(8'h50 + acc);
         @(negedge clk);
         if (drdy_a) acc++;
         @(posedge clk);
         #1;
      end
      srdy_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("async_acc", acc, 5);
      @(negedge clk);
      chk("async_head", {29'd0, head_a}, 32'b110);
      chk("async_full_wen", {31'd0, wen_a}, 32'd0);
      @(posedge clk);
      #1 rdp_a = 3'b011;
      @(negedge clk);
      chk("async_d0_wen", {31'd0, wen_a}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("async_d1_wen", {31'd0, wen_a}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("async_d2_wen", {31'd0, wen_a}, 32'd1);
      chk("async_d2_addr", {30'd0, waddr_a}, 32'd0);
      chk("async_d2_data", {24'd0, wdata_a}, 32'h54);
      @(posedge clk);
      #1;

      // Reset while two skid entries are pending.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         srdy = 1'b1;
         data = 8'(8'h60 + c);
         rdp  = '0;
         @(negedge clk);
         sb();
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("mid_pre_drdy", {31'd0, drdy}, 32'd0);
      chk("mid_pre_head", {29'd0, head}, 32'd4);
      sb();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      srdy  = 1'b0;
      #1;
      chk("mid_rst_wen", {31'd0, wen}, 32'd0);
      chk("mid_rst_drdy", {31'd0, drdy}, 32'd0);
      chk("mid_rst_head", {29'd0, head}, 32'd0);
      chk("mid_rst_addr", {30'd0, waddr}, 32'd0);
      q.delete();
      m_wp = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("mid_post%0d_drdy", c), {31'd0, drdy}, 32'd1);
         chk($sformatf("mid_post%0d_wen", c), {31'd0, wen}, 32'd0);
         sb();
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
